gate_sequencer: RTL and testbench
=================================

Name: gate_sequencer

Overview:
- Measurement controller for the frequency-meter counting datapath. It sits between the 1 MHz timebase and the 8-digit BCD edge counter.
- Owns the count gate, the synchronous counter clear and the display latch. Manual or automatic selection among three gate times (0.1 s, 1 s, 10 s).
- Reports the selected range for decimal-point placement, plus an overflow flag.
- Replaces the fixed 1 s free-running latch/clear scheme with an explicit state machine.

Parameters:
- GATE0_US, 100_000, gate length in 1 µs ticks for range 0 (0.1 s)
- GATE1_US, 1_000_000, gate length for range 1 (1 s)
- GATE2_US, 10_000_000, gate length for range 2 (10 s)
- HOLDOFF_US, 1_000, idle ticks between a latch and the next clear
- TW, 24, gate tick counter width; must hold GATE2_US

Ports:
- clk  in  1  system clock (10 or 50 MHz)
- rst_n  in  1  asynchronous active-low reset
- tick_1us  in  1  one-cycle strobe at 1 MHz from the prescaler
- sig_edge  in  1  one-cycle strobe per synchronized rising edge of the measured signal
- carry_out  in  1  BCD counter overflow strobe (count passed 99999999)
- msd_zero  in  1  BCD counter top two working digits are both zero (level)
- run  in  1  1 = measure continuously, 0 = stop
- range_mode  in  2  0 = auto, 1 = force range 0, 2 = force range 1, 3 = force range 2
- count_en  out  1  clock enable to the BCD counter, registered
- reset_ctr  out  1  synchronous clear of the working BCD counter, one-cycle pulse
- latchit  out  1  copy working count to display register, one-cycle pulse
- range  out  2  range of the currently displayed value (0..2)
- overflow  out  1  displayed value overflowed on range 0
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE; count_en = 0; reset_ctr = 0; latchit = 0; range = 1; overflow = 0; busy = 0; gate counter = 0; ovf_seen = 0; cur_range = 1.
- States: IDLE, CLEAR, GATE, SETTLE, DECIDE, LATCH, HOLDOFF.
- IDLE: when run = 1, go to CLEAR on the next cycle.
- CLEAR (1 cycle):
  - reset_ctr = 1; ovf_seen cleared.
  - Sample range_mode. A forced mode loads cur_range = range_mode-1. Auto keeps cur_range.
  - Gate counter = 0. Then go to GATE.
- GATE:
  - count_en registered as sig_edge AND (state == GATE), so it appears 1 cycle after the edge strobe.
  - Gate counter increments on tick_1us. When the counter equals GATEn_US-1 and tick_1us = 1, go to SETTLE.
  - Gate length is exactly GATEn_US ticks.
  - carry_out = 1 in GATE or SETTLE sets ovf_seen.
- SETTLE (1 cycle): lets the final registered count_en land. No new count_en is generated.
- DECIDE (1 cycle):
  - ovf_seen = 1, auto mode, cur_range > 0: cur_range decrements, go to CLEAR. No latch; display unchanged.
  - ovf_seen = 1, forced mode or cur_range = 0: go to LATCH with overflow flag pending.
  - Otherwise go to LATCH.
- LATCH (1 cycle):
  - latchit = 1.
  - range <= cur_range; overflow <= ovf_seen.
  - In auto mode, if msd_zero = 1 and ovf_seen = 0 and cur_range < 2, cur_range increments for the next measurement only.
  - Go to HOLDOFF.
- HOLDOFF: count HOLDOFF_US ticks, then go to CLEAR. If run = 0, go to IDLE instead.
- run = 0 in CLEAR, GATE, SETTLE or DECIDE: abort to IDLE next cycle. No latch; display outputs hold; count_en forced 0 in that same cycle.
- Simultaneous carry_out and final gate tick: counts as overflow.
- Simultaneous sig_edge and final gate tick: the edge is counted. Gate qualification uses the pre-transition state.
- range_mode change mid-measurement: ignored until the next CLEAR.
- reset_ctr and latchit are never high in the same cycle. count_en = 0 in every state except the cycle after a GATE edge.

Decomposition:
- Package freq_meas_pkg holds:
  - state enum
  - range encodings RANGE_100MS/1S/10S = 0/1/2
  - range_mode encodings
  - default gate-length constants shared with the display decimal-point decoder
- One sub-module, gate_timer: TW-bit tick counter with clear, tick enable and terminal-count input. It outputs a one-cycle done pulse. Instantiated once and reused for GATE and HOLDOFF via a muxed terminal count.

Test Plan (sim parameters: GATE0/1/2 = 10/100/1000, HOLDOFF = 5, tick_1us every 4 clk):
- Reset, then run = 1, range_mode = 2, sig_edge every 8 clk -> reset_ctr pulse, then exactly 100 ticks of gate. Expect 50 count_en pulses, one latchit, range = 1, overflow = 0.
- Auto mode, carry_out pulsed mid-gate on range 1 -> no latchit. Re-gates on range 0 for 10 ticks, then latchit with range = 0, overflow = 0.
- Auto mode, carry_out on every gate -> after stepping down to range 0: latchit, range = 0, overflow = 1.
- Auto mode, msd_zero = 1 at LATCH on range 1 -> latchit with range = 1. The next gate lasts 1000 ticks and latches range = 2.
- run dropped at gate tick 40 -> IDLE within 1 clk. No latchit; count_en = 0; range and overflow unchanged; busy = 0.
- sig_edge coincident with the final gate tick, and carry_out coincident with the same tick -> that edge produces count_en. Overflow path taken (range decrement in auto).

Source files
------------

// File: rtl/freq_meas_pkg.sv
// -----------------------------------------------------------------------------
// freq_meas_pkg
// Shared definitions for the frequency-meter measurement controller and the
// display decimal-point decoder: sequencer state encoding, range and
// range-mode encodings, and default gate / hold-off lengths in 1 us ticks.
// -----------------------------------------------------------------------------
package freq_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_DECIDE,
        ST_LATCH,
        ST_HOLDOFF
    } state_t;

    // Measurement range, also drives decimal-point placement
    localparam logic [1:0] RANGE_100MS = 2'd0;
    localparam logic [1:0] RANGE_1S    = 2'd1;
    localparam logic [1:0] RANGE_10S   = 2'd2;

    // range_mode input encoding
    localparam logic [1:0] MODE_AUTO        = 2'd0;
    localparam logic [1:0] MODE_FORCE_100MS = 2'd1;
    localparam logic [1:0] MODE_FORCE_1S    = 2'd2;
    localparam logic [1:0] MODE_FORCE_10S   = 2'd3;

    // Default gate lengths in 1 us ticks
    localparam int unsigned DEF_GATE0_US   = 100_000;
    localparam int unsigned DEF_GATE1_US   = 1_000_000;
    localparam int unsigned DEF_GATE2_US   = 10_000_000;
    localparam int unsigned DEF_HOLDOFF_US = 1_000;
    localparam int unsigned DEF_TW         = 24;

    // Range selected by a forced range_mode; MODE_AUTO has no forced range
    function automatic logic [1:0] forced_range(input logic [1:0] mode);
        logic [1:0] r;
        case (mode)
            MODE_FORCE_100MS: r = RANGE_100MS;
            MODE_FORCE_10S:   r = RANGE_10S;
            default:          r = RANGE_1S;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_sequencer_gate_timer.sv
// -----------------------------------------------------------------------------
// gate_timer
// TW-bit counter of 1 us ticks. Emits a one-cycle done pulse on the tick that
// brings the count to its terminal value (tc = length - 1), then wraps to 0.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, also suppresses done
//   tick  : count enable strobe
//   tc    : terminal count
//   done  : one-cycle pulse, tick && count == tc
// -----------------------------------------------------------------------------
module gate_timer
    import freq_meas_pkg::*;
#(
    parameter int unsigned TW = DEF_TW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          tick,
    input  logic [TW-1:0] tc,
    output logic          done
);

    logic [TW-1:0] cnt;

    always_comb begin
        done = tick && !clr && (cnt == tc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || done) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gate_sequencer.sv
// -----------------------------------------------------------------------------
// gate_sequencer
// Measurement controller for the frequency-meter datapath: owns the count
// gate, the working-counter clear and the display latch, and selects among
// three gate times manually or automatically.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   tick_1us   : 1 MHz strobe from the prescaler
//   sig_edge   : strobe per synchronized rising edge of the measured signal
//   carry_out  : BCD counter overflow strobe
//   msd_zero   : top two working BCD digits are zero (level)
//   run        : 1 = measure continuously, 0 = stop
//   range_mode : 0 auto, 1/2/3 force range 0/1/2
//   count_en   : registered clock enable to the BCD counter
//   reset_ctr  : one-cycle synchronous clear of the working counter
//   latchit    : one-cycle copy of working count to the display
//   range      : range of the displayed value
//   overflow   : displayed value overflowed on range 0
//   busy       : sequencer not idle
// -----------------------------------------------------------------------------
module gate_sequencer
    import freq_meas_pkg::*;
#(
    parameter int unsigned GATE0_US   = DEF_GATE0_US,
    parameter int unsigned GATE1_US   = DEF_GATE1_US,
    parameter int unsigned GATE2_US   = DEF_GATE2_US,
    parameter int unsigned HOLDOFF_US = DEF_HOLDOFF_US,
    parameter int unsigned TW         = DEF_TW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1us,
    input  logic       sig_edge,
    input  logic       carry_out,
    input  logic       msd_zero,
    input  logic       run,
    input  logic [1:0] range_mode,
    output logic       count_en,
    output logic       reset_ctr,
    output logic       latchit,
    output logic [1:0] range,
    output logic       overflow,
    output logic       busy
);

    localparam logic [TW-1:0] TC0 = TW'(GATE0_US - 1);
    localparam logic [TW-1:0] TC1 = TW'(GATE1_US - 1);
    localparam logic [TW-1:0] TC2 = TW'(GATE2_US - 1);
    localparam logic [TW-1:0] TCH = TW'(HOLDOFF_US - 1);

    state_t        state, state_nxt;
    logic [1:0]    cur_range;
    logic          auto_q;
    logic          ovf_seen;
    logic          timer_clr;
    logic          timer_done;
    logic [TW-1:0] timer_tc;

    // One timer serves both the gate and the hold-off; it only runs in those
    // two states, and is held cleared everywhere else.
    always_comb begin
        timer_clr = !((state == ST_GATE) || (state == ST_HOLDOFF));
        case (cur_range)
            RANGE_100MS: timer_tc = TC0;
            RANGE_1S:    timer_tc = TC1;
            default:     timer_tc = TC2;
        endcase
        if (state == ST_HOLDOFF) begin
            timer_tc = TCH;
        end
    end

    gate_timer #(.TW(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .tick  (tick_1us),
        .tc    (timer_tc),
        .done  (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (run) state_nxt = ST_CLEAR;
            ST_CLEAR:   state_nxt = run ? ST_GATE : ST_IDLE;
            ST_GATE: begin
                if (!run)            state_nxt = ST_IDLE;
                else if (timer_done) state_nxt = ST_SETTLE;
            end
            ST_SETTLE:  state_nxt = run ? ST_DECIDE : ST_IDLE;
            ST_DECIDE: begin
                if (!run)
                    state_nxt = ST_IDLE;
                else if (ovf_seen && auto_q && (cur_range != RANGE_100MS))
                    state_nxt = ST_CLEAR;
                else
                    state_nxt = ST_LATCH;
            end
            ST_LATCH:   state_nxt = ST_HOLDOFF;
            ST_HOLDOFF: begin
                if (!run)            state_nxt = ST_IDLE;
                else if (timer_done) state_nxt = ST_CLEAR;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        reset_ctr = (state == ST_CLEAR);
        latchit   = (state == ST_LATCH);
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_en  <= 1'b0;
            range     <= RANGE_1S;
            overflow  <= 1'b0;
            cur_range <= RANGE_1S;
            auto_q    <= 1'b0;
            ovf_seen  <= 1'b0;
        end else begin
            // Qualified by the pre-transition state, so an edge on the final
            // gate tick is still counted; run low suppresses it on abort.
            count_en <= sig_edge && (state == ST_GATE) && run;
            case (state)
                ST_CLEAR: begin
                    ovf_seen <= 1'b0;
                    auto_q   <= (range_mode == MODE_AUTO);
                    if (range_mode != MODE_AUTO) begin
                        cur_range <= forced_range(range_mode);
                    end
                end
                ST_GATE, ST_SETTLE: begin
                    if (carry_out) ovf_seen <= 1'b1;
                end
                ST_DECIDE: begin
                    if (run && ovf_seen && auto_q && (cur_range != RANGE_100MS)) begin
                        cur_range <= cur_range - 1'b1;
                    end
                end
                ST_LATCH: begin
                    range    <= cur_range;
                    overflow <= ovf_seen;
                    if (auto_q && msd_zero && !ovf_seen && (cur_range != RANGE_10S)) begin
                        cur_range <= cur_range + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_sequencer
// Directed bench for gate_sequencer with short gates (10/100/1000 ticks,
// hold-off 5) and tick_1us every 4 clocks. Inputs change 1 ns after the
// rising edge; the main sequence checks 2 ns after the rising edge; the
// measurement monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_gate_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tick_1us;
    logic       sig_edge;
    logic       carry_out;
    logic       msd_zero;
    logic       run;
    logic [1:0] range_mode;
    logic       count_en;
    logic       reset_ctr;
    logic       latchit;
    logic [1:0] range;
    logic       overflow;
    logic       busy;

    logic       carry_gen;
    logic       carry_force;
    int         edge_mode;   // 0 none, 1 every 8 clk (every other tick), 2 every tick
    bit         carry_mode;  // periodic carry pulses
    int         cyc;

    int n_cmp;
    int n_bad;

    // Monitor state, one record per measurement (reset by reset_ctr)
    int n_clear;
    int n_latch;
    int m_ticks;
    int m_ce;
    int prev_ce;
    int last_ticks;
    int last_ce;
    bit overlap;

    assign carry_out = carry_gen | carry_force;

    gate_sequencer #(
        .GATE0_US   (10),
        .GATE1_US   (100),
        .GATE2_US   (1000),
        .HOLDOFF_US (5),
        .TW         (24)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1us   (tick_1us),
        .sig_edge   (sig_edge),
        .carry_out  (carry_out),
        .msd_zero   (msd_zero),
        .run        (run),
        .range_mode (range_mode),
        .count_en   (count_en),
        .reset_ctr  (reset_ctr),
        .latchit    (latchit),
        .range      (range),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Timebase, edge and periodic carry generator
    initial begin
        cyc = 0;
        tick_1us = 1'b0;
        sig_edge = 1'b0;
        carry_gen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tick_1us  = (cyc % 4 == 0);
            sig_edge  = (edge_mode == 1) ? (cyc % 8 == 0) :
                        (edge_mode == 2) ? tick_1us : 1'b0;
            carry_gen = carry_mode && (cyc % 16 == 2);
        end
    end

    always @(negedge clk) begin
        if (reset_ctr) begin
            n_clear++;
            prev_ce = m_ce;
            m_ticks = 0;
            m_ce    = 0;
        end else begin
            if (tick_1us) m_ticks++;
            if (count_en) m_ce++;
        end
        if (latchit) begin
            n_latch++;
            last_ticks = m_ticks;
            last_ce    = m_ce;
        end
        if (reset_ctr && latchit) overlap = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_latch(input int target, input int budget, input string tag);
        int k = 0;
        while (n_latch < target && k < budget) begin
            step();
            k++;
        end
        check({tag, "_latch_wait"}, 32'(n_latch >= target), 1);
    endtask

    task automatic wait_clear(input int target, input int budget, input string tag);
        int k = 0;
        while (n_clear < target && k < budget) begin
            step();
            k++;
        end
        check({tag, "_clear_wait"}, 32'(n_clear >= target), 1);
    endtask

    // Return in the cycle whose tick_1us is gate tick number n
    task automatic wait_tick(input int n, input int budget, input string tag);
        int k = 0;
        while (!(m_ticks == n - 1 && tick_1us) && k < budget) begin
            step();
            k++;
        end
        check({tag, "_tick_wait"}, 32'(m_ticks == n - 1 && tick_1us), 1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        n_clear = 0; n_latch = 0; m_ticks = 0; m_ce = 0; prev_ce = 0;
        last_ticks = 0; last_ce = 0; overlap = 1'b0;
        edge_mode = 0; carry_mode = 1'b0; carry_force = 1'b0;
        rst_n = 1'b0; run = 1'b0; range_mode = 2'd0; msd_zero = 1'b0;

        // Reset values, during and after reset
        repeat (3) step();
        check("rst_count_en", count_en, 0);
        check("rst_reset_ctr", reset_ctr, 0);
        check("rst_latchit", latchit, 0);
        check("rst_range", range, 1);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) step();
        check("idle_busy", busy, 0);
        check("idle_range", range, 1);

        // T1: forced range 1, edge every other tick
        range_mode = 2'd2; edge_mode = 1; run = 1'b1;
        step();
        check("t1_clear_pulse", reset_ctr, 1);
        check("t1_clear_busy", busy, 1);
        check("t1_clear_nolatch", latchit, 0);
        step();
        check("t1_clear_one_cycle", reset_ctr, 0);
        wait_latch(1, 800, "t1");
        check("t1_gate_ticks", last_ticks, 100);
        check("t1_count_en", last_ce, 50);
        check("t1_clears", n_clear, 1);
        check("t1_range", range, 1);
        check("t1_overflow", overflow, 0);

        // T2: auto, carry mid-gate on range 1 -> re-gate on range 0
        range_mode = 2'd0;
        wait_clear(2, 200, "t2");
        wait_tick(50, 400, "t2");
        carry_force = 1'b1;
        step();
        carry_force = 1'b0;
        wait_latch(2, 800, "t2");
        check("t2_clears", n_clear, 3);
        check("t2_gate_ticks", last_ticks, 10);
        check("t2_count_en", last_ce, 5);
        check("t2_range", range, 0);
        check("t2_overflow", overflow, 0);

        // T4: auto, msd_zero high -> range climbs 0 -> 1 -> 2
        msd_zero = 1'b1;
        wait_latch(3, 200, "t4a");
        check("t4a_gate_ticks", last_ticks, 10);
        check("t4a_range", range, 0);
        wait_latch(4, 800, "t4b");
        check("t4b_gate_ticks", last_ticks, 100);
        check("t4b_range", range, 1);
        wait_latch(5, 6000, "t4c");
        check("t4c_gate_ticks", last_ticks, 1000);
        check("t4c_range", range, 2);
        check("t4c_overflow", overflow, 0);

        // T3: auto, carry in every gate -> steps 2 -> 1 -> 0, latches overflow
        msd_zero = 1'b0; carry_mode = 1'b1;
        wait_latch(6, 6000, "t3");
        check("t3_clears", n_clear, 9);
        check("t3_gate_ticks", last_ticks, 10);
        check("t3_range", range, 0);
        check("t3_overflow", overflow, 1);

        // T5: forced range 1, run dropped on gate tick 40 with an edge present
        carry_mode = 1'b0; range_mode = 2'd2; edge_mode = 2;
        wait_clear(10, 200, "t5");
        wait_tick(40, 400, "t5");
        run = 1'b0;
        step();
        check("t5_abort_busy", busy, 0);
        check("t5_abort_count_en", count_en, 0);
        check("t5_abort_reset_ctr", reset_ctr, 0);
        repeat (40) step();
        check("t5_no_latch", n_latch, 6);
        check("t5_no_clear", n_clear, 10);
        check("t5_range_held", range, 0);
        check("t5_overflow_held", overflow, 1);
        check("t5_idle_busy", busy, 0);

        // T6: auto on range 1, edge and carry both on the final gate tick
        range_mode = 2'd0; run = 1'b1;
        wait_clear(11, 20, "t6");
        wait_tick(100, 800, "t6");
        carry_force = 1'b1;
        step();
        carry_force = 1'b0;
        check("t6_final_edge_count_en", count_en, 1);
        wait_latch(7, 400, "t6");
        check("t6_clears", n_clear, 12);
        check("t6_first_gate_count_en", prev_ce, 100);
        check("t6_gate_ticks", last_ticks, 10);
        check("t6_count_en", last_ce, 10);
        check("t6_range", range, 0);
        check("t6_overflow", overflow, 0);

        run = 1'b0;
        repeat (30) step();
        check("end_busy", busy, 0);
        check("clear_latch_overlap", 32'(overlap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
